aes128_dec_iter_ctrl: RTL

Iterative AES-128 decryption engine: accepts one 128-bit ciphertext block over a valid/ready handshake and runs the inverse cipher one round per clock. It owns the state register, the round counter and the round FSM, and drives the inverse datapath each cycle: inverse shift-rows, inverse sub-bytes, add-round-key, inverse mix-columns. Round keys come from an external key store addressed by this block. It sits between the decryption input stream and the plaintext output stream.

---
 rtl/aes128_dec_iter_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/aes128_dec_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aes128_dec_iter_ctrl
// Brief    : Iterative AES-128 inverse cipher, one round per clock, with an
//            external round-key store addressed through rk_idx.
// Revision : 1.0
// ============================================================================
module aes128_dec_iter_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ct_in,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] pt_out,
    output logic         busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] C_RK_LAST  = 4'd10;
    localparam logic [3:0] C_RND_INIT = 4'd9;

    state_t       r_state, w_state_nxt;
    logic [127:0] r_s, w_s_nxt;
    logic [3:0]   r_rnd, w_rnd_nxt;
    logic [127:0] w_isr, w_isb, w_ark, w_imc;

    function automatic logic [7:0] gf_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = gf_xtime(p);
        end
        return acc;
    endfunction

    // Multiplicative inverse as x^254 (0 maps to 0).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        acc = 8'h01;
        sq  = x;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    // Inverse affine transform followed by field inversion.
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] x;
        logic [7:0] d;
        d = 8'h05;
        for (int i = 0; i < 8; i++) begin
            x[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8] ^ d[i];
        end
        return gf_inv(x);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    // Byte i sits at [127-8i -: 8]; row = i%4, column = i/4.
    for (genvar gi = 0; gi < 16; gi++) begin : g_byte
        localparam int C_ROW = gi % 4;
        localparam int C_COL = gi / 4;
        localparam int C_SRC = C_ROW + 4 * ((C_COL - C_ROW + 4) % 4);
        assign w_isr[127-8*gi -: 8] = r_s[127-8*C_SRC -: 8];
        assign w_isb[127-8*gi -: 8] = inv_sbox(w_isr[127-8*gi -: 8]);
    end

    assign w_ark = w_isb ^ rk;

    for (genvar gc = 0; gc < 4; gc++) begin : g_col
        assign w_imc[127-32*gc -: 32] = inv_mix_col(w_ark[127-32*gc -: 32]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_s     <= '0;
            r_rnd   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_rnd   <= w_rnd_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_rnd_nxt   = r_rnd;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_s_nxt     = ct_in ^ rk;
                    w_rnd_nxt   = C_RND_INIT;
                    w_state_nxt = ST_ROUND;
                end
            end
            ST_ROUND: begin
                w_s_nxt = w_imc;
                if (r_rnd == 4'd1) w_state_nxt = ST_FINAL;
                else               w_rnd_nxt   = r_rnd - 4'd1;
            end
            ST_FINAL: begin
                w_s_nxt     = w_ark;
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        rk_idx = C_RK_LAST;
        case (r_state)
            ST_ROUND: rk_idx = r_rnd;
            ST_FINAL: rk_idx = 4'd0;
            default:  rk_idx = C_RK_LAST;
        endcase
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state == ST_ROUND) || (r_state == ST_FINAL);
    assign pt_out    = r_s;

endmodule
`default_nettype wire
